// File: rtl/control_pkg.sv
// Shared constants, state/class types and opcode classification for control_sequencer.
package control_pkg;

    localparam int CODE_W = 5;

    localparam logic [CODE_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [CODE_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [CODE_W-1:0] OP_AND  = 5'b00101;
    localparam logic [CODE_W-1:0] OP_OR   = 5'b00110;
    localparam logic [CODE_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [CODE_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [CODE_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [CODE_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [CODE_W-1:0] OP_HALT = 5'b11011;

    localparam logic [CODE_W-1:0] ALU_NONE = 5'b00000;
    localparam logic [CODE_W-1:0] ALU_ADD  = 5'b00011;
    localparam logic [CODE_W-1:0] ALU_SUB  = 5'b00100;
    localparam logic [CODE_W-1:0] ALU_AND  = 5'b00101;
    localparam logic [CODE_W-1:0] ALU_OR   = 5'b00110;

    // T0-T2 fetch, T1W memory wait, T3-T5 execute, WAIT_STEP single-step hold
    typedef enum logic [3:0] {
        IDLE, T0, T1, T1W, T2, T3, T4, T5, HALTED, WAIT_STEP
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic pc_out;
        logic zlo_out;
        logic mdr_out;
        logic c_out;
        logic r_out;
        logic mar_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic z_in;
        logic r_in;
        logic gra;
        logic grb;
        logic grc;
        logic inc_pc;
        logic read;
        logic run;
    } strobes_t;

    function automatic op_class_t decode_class(input logic [CODE_W-1:0] op);
        op_class_t cls;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_R;
            OP_ADDI, OP_ANDI, OP_ORI:      cls = CLS_I;
            OP_NOP:                        cls = CLS_NOP;
            OP_HALT:                       cls = CLS_HALT;
            default:                       cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

    function automatic logic [CODE_W-1:0] alu_code(input logic [CODE_W-1:0] op);
        logic [CODE_W-1:0] code;
        case (op)
            OP_ADD, OP_ADDI: code = ALU_ADD;
            OP_SUB:          code = ALU_SUB;
            OP_AND, OP_ANDI: code = ALU_AND;
            OP_OR, OP_ORI:   code = ALU_OR;
            default:         code = ALU_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/opcode_decoder.sv
// Combinational opcode classifier: IR opcode field -> instruction class and ALU operation.
module opcode_decoder
    import control_pkg::*;
#(
    parameter int OP_W = 5
) (
    input  logic [OP_W-1:0]   opcode,
    output op_class_t         op_class,
    output logic [CODE_W-1:0] alu_op
);

    always_comb begin
        op_class = decode_class(CODE_W'(opcode));
        alu_op   = alu_code(CODE_W'(opcode));
    end

endmodule

// File: rtl/control_sequencer.sv
// Fetch/execute strobe sequencer for the datapath; all outputs are registered Moore outputs.
// Optional CONTROL_SEQUENCER_STEP_EN adds a Step input and a WAIT_STEP hold between instructions.
module control_sequencer
    import control_pkg::*;
#(
    parameter int ALU_W = 5,
    parameter int OP_W  = 5
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic             Mem_Ready,
`ifdef CONTROL_SEQUENCER_STEP_EN
    input  logic             Step,
`endif
    input  logic [31:0]      IR,
    output logic             PC_Out,
    output logic             ZLO_Out,
    output logic             MDR_Out,
    output logic             C_Out,
    output logic             R_Out,
    output logic             MAR_In,
    output logic             PC_In,
    output logic             MDR_In,
    output logic             IR_In,
    output logic             Y_In,
    output logic             Z_In,
    output logic             R_In,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             IncPC,
    output logic             Read,
    output logic [ALU_W-1:0] CONTROL,
    output logic             Run,
    output logic             Illegal
);

`ifdef CONTROL_SEQUENCER_STEP_EN
    localparam state_t DONE_STATE = WAIT_STEP;
`else
    localparam state_t DONE_STATE = T0;
`endif

    state_t            state;
    state_t            next_state;
    op_class_t         dec_cls;
    op_class_t         cls_q;
    logic [CODE_W-1:0] dec_alu;
    logic [CODE_W-1:0] alu_q;
    strobes_t          strb_q;
    strobes_t          nxt_strb;
    logic [ALU_W-1:0]  ctrl_q;
    logic [ALU_W-1:0]  nxt_ctrl;
    logic              illegal_q;
    logic              nxt_illegal;
    logic              unused_ir;

    assign unused_ir = ^IR[31-OP_W:0];

    opcode_decoder #(.OP_W(OP_W)) u_dec (
        .opcode   (IR[31 -: OP_W]),
        .op_class (dec_cls),
        .alu_op   (dec_alu)
    );

    // The opcode class is captured on the edge into T3 so T3's exit and T4 ignore later IR changes.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state     <= IDLE;
            strb_q    <= '0;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            cls_q     <= CLS_NOP;
            alu_q     <= ALU_NONE;
        end else begin
            state     <= next_state;
            strb_q    <= nxt_strb;
            ctrl_q    <= nxt_ctrl;
            illegal_q <= nxt_illegal;
            if (state == T2) begin
                cls_q <= dec_cls;
                alu_q <= dec_alu;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (Start) next_state = T0;
            T0:     next_state = T1;
            T1:     next_state = Mem_Ready ? T2 : T1W;
            T1W:    if (Mem_Ready) next_state = T2;
            T2:     next_state = T3;
            T3: begin
                case (cls_q)
                    CLS_R, CLS_I: next_state = T4;
                    CLS_HALT:     next_state = HALTED;
                    default:      next_state = DONE_STATE;
                endcase
            end
            T4:     next_state = T5;
            T5:     next_state = DONE_STATE;
            HALTED: next_state = HALTED;
            WAIT_STEP: begin
`ifdef CONTROL_SEQUENCER_STEP_EN
                if (Step) next_state = T0;
`else
                next_state = T0;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered, so they line up with the registered state.
    always_comb begin
        nxt_strb = '0;
        nxt_ctrl = '0;
        case (next_state)
            T0: begin
                nxt_strb.pc_out = 1'b1;
                nxt_strb.mar_in = 1'b1;
                nxt_strb.inc_pc = 1'b1;
                nxt_strb.z_in   = 1'b1;
            end
            T1: begin
                nxt_strb.zlo_out = 1'b1;
                nxt_strb.pc_in   = 1'b1;
                nxt_strb.read    = 1'b1;
                nxt_strb.mdr_in  = 1'b1;
            end
            T1W: begin
                nxt_strb.read   = 1'b1;
                nxt_strb.mdr_in = 1'b1;
            end
            T2: begin
                nxt_strb.mdr_out = 1'b1;
                nxt_strb.ir_in   = 1'b1;
            end
            T3: begin
                if (dec_cls == CLS_R || dec_cls == CLS_I) begin
                    nxt_strb.grb   = 1'b1;
                    nxt_strb.r_out = 1'b1;
                    nxt_strb.y_in  = 1'b1;
                end
            end
            T4: begin
                nxt_strb.z_in = 1'b1;
                if (cls_q == CLS_R) begin
                    nxt_strb.grc   = 1'b1;
                    nxt_strb.r_out = 1'b1;
                end else begin
                    nxt_strb.c_out = 1'b1;
                end
                nxt_ctrl = ALU_W'(alu_q);
            end
            T5: begin
                nxt_strb.zlo_out = 1'b1;
                nxt_strb.gra     = 1'b1;
                nxt_strb.r_in    = 1'b1;
            end
            default: ;
        endcase
        nxt_strb.run = (next_state != IDLE) && (next_state != HALTED);
        nxt_illegal  = illegal_q || (next_state == T3 && dec_cls == CLS_ILLEGAL);
    end

    assign PC_Out  = strb_q.pc_out;
    assign ZLO_Out = strb_q.zlo_out;
    assign MDR_Out = strb_q.mdr_out;
    assign C_Out   = strb_q.c_out;
    assign R_Out   = strb_q.r_out;
    assign MAR_In  = strb_q.mar_in;
    assign PC_In   = strb_q.pc_in;
    assign MDR_In  = strb_q.mdr_in;
    assign IR_In   = strb_q.ir_in;
    assign Y_In    = strb_q.y_in;
    assign Z_In    = strb_q.z_in;
    assign R_In    = strb_q.r_in;
    assign Gra     = strb_q.gra;
    assign Grb     = strb_q.grb;
    assign Grc     = strb_q.grc;
    assign IncPC   = strb_q.inc_pc;
    assign Read    = strb_q.read;
    assign Run     = strb_q.run;
    assign CONTROL = ctrl_q;
    assign Illegal = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench: each instruction expands into its expected per-cycle strobe vectors,
// which a negedge monitor compares against the DUT outputs.
module tb_control_sequencer;

    localparam logic [23:0] B_PC_OUT  = 24'h000001;
    localparam logic [23:0] B_ZLO_OUT = 24'h000002;
    localparam logic [23:0] B_MDR_OUT = 24'h000004;
    localparam logic [23:0] B_C_OUT   = 24'h000008;
    localparam logic [23:0] B_R_OUT   = 24'h000010;
    localparam logic [23:0] B_MAR_IN  = 24'h000020;
    localparam logic [23:0] B_PC_IN   = 24'h000040;
    localparam logic [23:0] B_MDR_IN  = 24'h000080;
    localparam logic [23:0] B_IR_IN   = 24'h000100;
    localparam logic [23:0] B_Y_IN    = 24'h000200;
    localparam logic [23:0] B_Z_IN    = 24'h000400;
    localparam logic [23:0] B_R_IN    = 24'h000800;
    localparam logic [23:0] B_GRA     = 24'h001000;
    localparam logic [23:0] B_GRB     = 24'h002000;
    localparam logic [23:0] B_GRC     = 24'h004000;
    localparam logic [23:0] B_INCPC   = 24'h008000;
    localparam logic [23:0] B_READ    = 24'h010000;
    localparam logic [23:0] B_RUN     = 24'h400000;
    localparam logic [23:0] B_ILL     = 24'h800000;

    localparam logic [23:0] V_T0  = B_PC_OUT | B_MAR_IN | B_INCPC | B_Z_IN | B_RUN;
    localparam logic [23:0] V_T1  = B_ZLO_OUT | B_PC_IN | B_READ | B_MDR_IN | B_RUN;
    localparam logic [23:0] V_T1W = B_READ | B_MDR_IN | B_RUN;
    localparam logic [23:0] V_T2  = B_MDR_OUT | B_IR_IN | B_RUN;
    localparam logic [23:0] V_T3X = B_GRB | B_R_OUT | B_Y_IN | B_RUN;
    localparam logic [23:0] V_T4R = B_GRC | B_R_OUT | B_Z_IN | B_RUN;
    localparam logic [23:0] V_T4I = B_C_OUT | B_Z_IN | B_RUN;
    localparam logic [23:0] V_T5  = B_ZLO_OUT | B_GRA | B_R_IN | B_RUN;

`ifdef CONTROL_SEQUENCER_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    logic        Clock = 1'b0;
    logic        Reset_n, Start, Mem_Ready, Step;
    logic [31:0] IR;
    logic        PC_Out, ZLO_Out, MDR_Out, C_Out, R_Out;
    logic        MAR_In, PC_In, MDR_In, IR_In, Y_In, Z_In, R_In;
    logic        Gra, Grb, Grc, IncPC, Read, Run, Illegal;
    logic [4:0]  CONTROL;
    logic [23:0] act;

    logic [23:0] exp_q[$];
    int          cyc_q[$];
    string       lbl_q[$];
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    bit          illegal_m = 1'b0;

    logic [4:0]  legal_ops [8] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                   5'b01100, 5'b01101, 5'b01110, 5'b11010};

    control_sequencer #(.ALU_W(5), .OP_W(5)) dut (
        .Clock     (Clock),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .Mem_Ready (Mem_Ready),
`ifdef CONTROL_SEQUENCER_STEP_EN
        .Step      (Step),
`endif
        .IR        (IR),
        .PC_Out    (PC_Out),
        .ZLO_Out   (ZLO_Out),
        .MDR_Out   (MDR_Out),
        .C_Out     (C_Out),
        .R_Out     (R_Out),
        .MAR_In    (MAR_In),
        .PC_In     (PC_In),
        .MDR_In    (MDR_In),
        .IR_In     (IR_In),
        .Y_In      (Y_In),
        .Z_In      (Z_In),
        .R_In      (R_In),
        .Gra       (Gra),
        .Grb       (Grb),
        .Grc       (Grc),
        .IncPC     (IncPC),
        .Read      (Read),
        .CONTROL   (CONTROL),
        .Run       (Run),
        .Illegal   (Illegal)
    );

    assign act = {Illegal, Run, CONTROL, Read, IncPC, Grc, Grb, Gra, R_In, Z_In, Y_In,
                  IR_In, MDR_In, PC_In, MAR_In, R_Out, C_Out, MDR_Out, ZLO_Out, PC_Out};

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // 0 = R-type, 1 = I-type, 2 = NOP, 3 = HALT, 4 = illegal
    function automatic int op_kind(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110: return 0;
            5'b01100, 5'b01101, 5'b01110:           return 1;
            5'b11010:                               return 2;
            5'b11011:                               return 3;
            default:                                return 4;
        endcase
    endfunction

    function automatic logic [4:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00011, 5'b01100: return 5'b00011;
            5'b00100:           return 5'b00100;
            5'b00101, 5'b01101: return 5'b00101;
            5'b00110, 5'b01110: return 5'b00110;
            default:            return 5'b00000;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive inputs for the coming edge and queue what the DUT must show after it.
    task automatic drive(input logic [23:0] v, input string lbl, input logic rst,
                         input logic st, input logic mr, input logic [31:0] ir, input logic stp);
        Reset_n   = rst;
        Start     = st;
        Mem_Ready = mr;
        IR        = ir;
        Step      = stp;
        if (!rst) illegal_m = 1'b0;
        exp_q.push_back(rst ? (v | (illegal_m ? B_ILL : 24'h0)) : 24'h0);
        cyc_q.push_back(cyc + 1);
        lbl_q.push_back(lbl);
        @(posedge Clock);
        #1;
    endtask

    task automatic run_instr(input logic [31:0] ir, input int waits, input bit from_idle,
                             input bit abort_t4);
        int          kind;
        logic [23:0] ctrl;
        kind = op_kind(ir[31:27]);
        ctrl = {14'b0, alu_of(ir[31:27]), 5'b0} << 12;
        drive(V_T0, "t0", 1'b1, from_idle ? 1'b1 : rb(), rb(), $urandom, 1'b1);
        drive(V_T1, "t1", 1'b1, rb(), rb(), $urandom, rb());
        for (int i = 0; i < waits; i++)
            drive(V_T1W, "t1w", 1'b1, rb(), 1'b0, $urandom, rb());
        drive(V_T2, "t2", 1'b1, rb(), 1'b1, $urandom, rb());
        if (kind == 4) illegal_m = 1'b1;
        drive((kind < 2) ? V_T3X : B_RUN, "t3", 1'b1, rb(), rb(), ir, rb());
        if (kind < 2) begin
            drive(((kind == 0) ? V_T4R : V_T4I) | ctrl, "t4", 1'b1, rb(), rb(), $urandom, rb());
            if (abort_t4) begin
                drive(24'h0, "abort", 1'b0, rb(), rb(), $urandom, rb());
                return;
            end
            drive(V_T5, "t5", 1'b1, rb(), rb(), $urandom, rb());
        end else if (kind == 3) begin
            for (int i = 0; i < 20; i++)
                drive(24'h0, "halted", 1'b1, (i % 2 == 0) ? 1'b1 : rb(), rb(), $urandom, rb());
            return;
        end
        if (STEP_MODE) begin
            int n;
            n = $urandom_range(0, 3);
            drive(B_RUN, "wait_step", 1'b1, rb(), rb(), $urandom, rb());
            for (int i = 0; i < n; i++)
                drive(B_RUN, "wait_step", 1'b1, rb(), rb(), $urandom, 1'b0);
        end
    endtask

    task automatic rand_legal(input int n);
        for (int i = 0; i < n; i++)
            run_instr({legal_ops[$urandom_range(0, 7)], 27'($urandom)}, $urandom_range(0, 3), 1'b0, 1'b0);
    endtask

    task automatic rand_mix(input int n);
        logic [4:0] op;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                do op = 5'($urandom); while (op_kind(op) != 4);
            end else begin
                op = legal_ops[$urandom_range(0, 7)];
            end
            run_instr({op, 27'($urandom)}, $urandom_range(0, 3), 1'b0, 1'b0);
        end
    endtask

    always @(negedge Clock) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            int          c;
            logic [23:0] e;
            string       l;
            c = cyc_q.pop_front();
            e = exp_q.pop_front();
            l = lbl_q.pop_front();
            total++;
            if (c != cyc || act !== e) begin
                bad++;
                $display("FAIL %s cyc=%0d sched=%0d got=%h want=%h", l, cyc, c, act, e);
            end
        end
    end

    initial begin
        Reset_n = 1'b0; Start = 1'b1; Mem_Ready = 1'b0; IR = '0; Step = 1'b0;
        drive(24'h0, "reset", 1'b0, 1'b1, rb(), $urandom, rb());
        drive(24'h0, "reset", 1'b0, 1'b1, rb(), $urandom, rb());
        run_instr(32'h19A00000, 0, 1'b1, 1'b0);
        run_instr(32'h70800005, 3, 1'b0, 1'b0);
        rand_legal(25);
        run_instr({5'b11111, 27'($urandom)}, 0, 1'b0, 1'b0);
        rand_mix(20);
        run_instr({5'b11011, 27'($urandom)}, $urandom_range(0, 2), 1'b0, 1'b0);
        drive(24'h0, "reset", 1'b0, rb(), rb(), $urandom, rb());
        drive(24'h0, "reset", 1'b0, rb(), rb(), $urandom, rb());
        drive(24'h0, "idle", 1'b1, 1'b0, rb(), $urandom, rb());
        drive(24'h0, "idle", 1'b1, 1'b0, rb(), $urandom, rb());
        run_instr(32'h19A00000, 0, 1'b1, 1'b0);
        run_instr(32'h19A00000, 1, 1'b0, 1'b1);
        drive(24'h0, "idle", 1'b1, 1'b0, rb(), $urandom, rb());
        run_instr({5'b00100, 27'($urandom)}, 2, 1'b1, 1'b0);
        rand_legal(8);
        repeat (3) @(posedge Clock);
        total++;
        if (cyc_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", cyc_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
